// File: rtl/pio_input_pkg.sv
// Shared constants for the Avalon-MM input PIO: register addresses,
// edge-type encodings and the default debounce length.
package pio_input_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam logic [15:0] DEFAULT_DEBOUNCE_CYCLES = 16'd50000;

endpackage

// File: rtl/pio_debounce_bit.sv
// Single-bit debouncer: a level is accepted onto stable_o only after the
// synchronised input has differed from it for DEBOUNCE_CYCLES clocks in a row.
module pio_debounce_bit
    import pio_input_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_i,
    output logic stable_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        stable_q, stable_d;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sample_i != stable_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                stable_d = sample_i;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Counter and accepted level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/avalon_pio_input_capture.sv
// Avalon-MM input PIO: synchronises in_port, detects per-bit edges into a
// sticky write-1-to-clear capture register and drives a masked level irq.
// Optional build macro PIO_INPUT_DEBOUNCE_EN inserts a per-bit debouncer
// between the synchroniser and the edge detector.
module avalon_pio_input_capture
    import pio_input_pkg::*;
#(
    parameter int          WIDTH           = 8,
    parameter int          EDGE_TYPE       = EDGE_RISE,
    parameter logic [15:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;

`ifdef PIO_INPUT_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .sample_i(sync2_q[i]),
            .stable_o(level[i])
        );
    end
    logic unused_wdata;
    assign unused_wdata = ^writedata;
`else
    assign level = sync2_q;
    logic unused_cfg;
    assign unused_cfg = ^{writedata, DEBOUNCE_CYCLES};
`endif

    assign wr_en = chipselect && !write_n;

    // Per-bit edge event for the configured polarity.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_evt = ~level & prev_q;
            EDGE_ANY:  edge_evt = level ^ prev_q;
            default:   edge_evt = level & ~prev_q;
        endcase
    end

    // Next-state for mask and capture; a same-cycle event beats a clear.
    always_comb begin
        clr_bits   = '0;
        irq_mask_d = irq_mask_q;
        if (wr_en && address == ADDR_EDGE_CAP) clr_bits   = writedata[WIDTH-1:0];
        if (wr_en && address == ADDR_IRQ_MASK) irq_mask_d = writedata[WIDTH-1:0];
        edge_cap_d = edge_evt | (edge_cap_q & ~clr_bits);
    end

    // Synchroniser, edge history and software-visible registers.
    // NOTE: non-blocking assignments here so every flop samples pre-edge values;
    // blocking would collapse the 2-flop synchroniser into a single stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            prev_q     <= level;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    // Zero-wait-state read mux, independent of chipselect.
    // NOTE: readdata defaults to zero first so no address path infers a latch.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = level;
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_cap_q;
            default:       readdata = '0;
        endcase
    end

    assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_avalon_pio_input_capture.sv
// Directed bench for avalon_pio_input_capture: three instances (rising,
// falling, any-edge) share one bus and in_port; reads go through a scoreboard.
module tb_avalon_pio_input_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_r, rd_f, rd_a;
    logic        irq_r, irq_f, irq_a;

    int vectors = 0;
    int miss    = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;
    sb_item_t sb[$];

    always #5 clk = ~clk;

    avalon_pio_input_capture #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16'd4)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_r), .irq(irq_r));

    avalon_pio_input_capture #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(16'd4)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_f), .irq(irq_f));

    avalon_pio_input_capture #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16'd4)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 = rising instance, 1 = falling, 2 = any
    task automatic rd(input int which, input logic [1:0] addr, input logic [31:0] exp,
                      input string tag);
        sb_item_t it;
        logic [31:0] obs;
        sb.push_back('{tag: tag, exp: exp});
        address = addr;
        #1;
        obs = (which == 0) ? rd_r : (which == 1) ? rd_f : rd_a;
        it  = sb.pop_front();
        check(it.tag, obs, it.exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h00;
        tick(2);
        reset_n = 1'b1;

        // Reset state
        rd(0, 2'd0, 32'h0, "rst_data");
        rd(0, 2'd1, 32'h0, "rst_resv");
        rd(0, 2'd2, 32'h0, "rst_mask");
        rd(0, 2'd3, 32'h0, "rst_cap");
        check("rst_irq", {31'b0, irq_r}, 32'h0);

        // Register width and reserved address
        wr(2'd2, 32'hFFFF_FFFF);
        rd(0, 2'd2, 32'h0000_00FF, "mask_width");
        wr(2'd1, 32'hFFFF_FFFF);
        rd(0, 2'd1, 32'h0, "resv_write");

`ifdef PIO_INPUT_DEBOUNCE_EN
        wr(2'd2, 32'h01);
        // 2-cycle glitch on bit 0 is filtered out
        in_port = 8'h01;
        tick(2);
        in_port = 8'h00;
        tick(10);
        rd(0, 2'd0, 32'h00, "db_glitch_data");
        rd(0, 2'd3, 32'h00, "db_glitch_cap");
        // A held level is accepted and captured
        in_port = 8'h01;
        tick(10);
        rd(0, 2'd0, 32'h01, "db_held_data");
        rd(0, 2'd3, 32'h01, "db_held_cap");
        check("db_held_irq", {31'b0, irq_r}, 32'h1);
`else
        // Rising edge on bit 0: DATA after 2 edges, capture and irq after 3
        wr(2'd2, 32'h01);
        in_port = 8'h01;
        tick(2);
        rd(0, 2'd0, 32'h01, "lat_data");
        rd(0, 2'd3, 32'h00, "lat_cap_early");
        tick(1);
        rd(0, 2'd3, 32'h01, "rise_cap");
        check("rise_irq", {31'b0, irq_r}, 32'h1);
        rd(1, 2'd3, 32'h00, "fall_no_cap");
        wr(2'd3, 32'h01);
        rd(0, 2'd3, 32'h00, "w1c_cap");
        check("w1c_irq", {31'b0, irq_r}, 32'h0);

        // Set wins over a same-cycle clear on bit 3
        in_port = 8'h09;
        tick(3);
        rd(0, 2'd3, 32'h08, "b3_cap");
        in_port = 8'h01;
        tick(3);
        rd(0, 2'd3, 32'h08, "b3_hold_on_fall");
        in_port = 8'h09;
        tick(2);
        wr(2'd3, 32'h08);
        rd(0, 2'd3, 32'h08, "set_wins");
        wr(2'd3, 32'h08);
        rd(0, 2'd3, 32'h00, "b3_cleared");

        // Masked capture, then unmask
        wr(2'd2, 32'h00);
        wr(2'd3, 32'hFF);
        in_port = 8'h29;
        tick(3);
        rd(0, 2'd3, 32'h20, "b5_cap_masked");
        check("b5_irq_masked", {31'b0, irq_r}, 32'h0);
        wr(2'd2, 32'h20);
        check("b5_irq_unmask", {31'b0, irq_r}, 32'h1);
        wr(2'd2, 32'h00);
        check("b5_irq_remask", {31'b0, irq_r}, 32'h0);
        rd(0, 2'd3, 32'h20, "mask_keeps_cap");

        // Any-edge: pulse bit 7, capture rise, clear, capture fall
        wr(2'd3, 32'hFF);
        in_port = 8'hA9;
        tick(3);
        rd(2, 2'd3, 32'h80, "any_rise_cap");
        rd(2, 2'd0, 32'hA9, "any_data");
        wr(2'd3, 32'h80);
        rd(2, 2'd3, 32'h00, "any_cleared");
        tick(1);
        in_port = 8'h29;
        tick(3);
        rd(2, 2'd3, 32'h80, "any_fall_cap");
        rd(1, 2'd3, 32'h80, "fall_cap");
        rd(0, 2'd3, 32'h00, "rise_ignores_fall");

        // Async reset while irq is high
        wr(2'd2, 32'h80);
        check("pre_rst_irq", {31'b0, irq_a}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("async_rst_irq", {31'b0, irq_a}, 32'h0);
        rd(2, 2'd3, 32'h00, "async_rst_cap");
        @(negedge clk);
        reset_n = 1'b1;
        // Inputs high at release look like rising edges
        tick(3);
        rd(0, 2'd3, 32'h29, "release_rise_cap");
        rd(1, 2'd3, 32'h00, "release_fall_cap");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
